// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_pkg
//  Description : Shared types and constants for the flappy game sequencer:
//                game-state and key-decoder encodings, PS/2 scan codes,
//                datapath widths and a saturating score increment.
//  Revision    : 1.0  initial release
// ============================================================================
package flappy_pkg;

   // Game state encoding as seen on o_game_state; 2'd3 is illegal
   typedef enum logic [1:0] {
      GS_IDLE = 2'd0,
      GS_PLAY = 2'd1,
      GS_DEAD = 2'd2
   } game_state_t;

   // PS/2 prefix tracking for the space-bar decoder
   typedef enum logic [1:0] {
      DEC_NORMAL = 2'd0,
      DEC_BREAK  = 2'd1,
      DEC_EXT    = 2'd2
   } dec_state_t;

   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // Signed velocity width
   localparam int VEL_W = 12;
   // Stored bird row width (covers the 0..479 visible range)
   localparam int POS_W = 12;
   // Signed width for row arithmetic, wide enough that pos+vel never wraps
   localparam int Y_W   = 14;

   // Score counter stops at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flappy_game_sequencer_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_space_decoder
//  Description : Turns the PS/2 byte stream into a sticky flap request.
//                Only a fresh space make code flaps; typematic repeats,
//                break sequences and extended (E0-prefixed) keys do not.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_space_decoder
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_key_valid,
   input  logic [7:0] i_key_data,
   input  logic       i_consume,
   output logic       o_flap_req
);

   dec_state_t r_state;
   dec_state_t w_state_n;
   logic       r_space_held;
   logic       w_space_held_n;
   logic       r_flap_req;
   logic       w_flap_req_n;
   logic       w_flap_set;

   // Prefix state, key-held flag and pending flap request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= DEC_NORMAL;
         r_space_held <= 1'b0;
         r_flap_req   <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_space_held <= w_space_held_n;
         r_flap_req   <= w_flap_req_n;
      end
   end

   // Byte decode; a new flap on the consume cycle survives for the next tick
   always_comb begin
      w_state_n      = r_state;
      w_space_held_n = r_space_held;
      w_flap_set     = 1'b0;
      if (i_key_valid) begin
         case (r_state)
            DEC_NORMAL: begin
               if (i_key_data == SC_SPACE) begin
                  if (!r_space_held) begin
                     w_flap_set     = 1'b1;
                     w_space_held_n = 1'b1;
                  end
               end else if (i_key_data == SC_BREAK) begin
                  w_state_n = DEC_BREAK;
               end else if (i_key_data == SC_EXT) begin
                  w_state_n = DEC_EXT;
               end
            end
            DEC_BREAK: begin
               if (i_key_data == SC_SPACE) begin
                  w_space_held_n = 1'b0;
               end
               w_state_n = DEC_NORMAL;
            end
            DEC_EXT: begin
               w_state_n = (i_key_data == SC_BREAK) ? DEC_BREAK : DEC_NORMAL;
            end
            default: begin
               w_state_n = DEC_NORMAL;
            end
         endcase
      end
      if (w_flap_set) begin
         w_flap_req_n = 1'b1;
      end else if (i_consume) begin
         w_flap_req_n = 1'b0;
      end else begin
         w_flap_req_n = r_flap_req;
      end
   end

   assign o_flap_req = r_flap_req;

endmodule
`default_nettype wire

// File: rtl/flappy_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_game_sequencer
//  Description : Game-level controller. Synchronises VGA V_SYNC into a
//                one-per-frame tick, runs the IDLE/PLAY/DEAD game FSM with
//                per-frame bird physics, and keeps the saturating score.
//  Revision    : 1.0  initial release
// ============================================================================
module flappy_game_sequencer
   import flappy_pkg::*;
#(
   parameter int BIRD_Y_INIT = 240,
   parameter int FLOOR_Y     = 440,
   parameter int CEIL_Y      = 0,
   parameter int GRAVITY     = 1,
   parameter int FLAP_VEL    = -8,
   parameter int VEL_MAX     = 10,
   parameter int DEAD_FRAMES = 60
)
(
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        i_vga_vs,
   input  logic        i_key_valid,
   input  logic [7:0]  i_key_data,
   input  logic        i_collide,
   input  logic        i_pipe_pass,
   output logic [31:0] o_bird_y,
   output logic [1:0]  o_game_state,
   output logic [15:0] o_score,
   output logic        o_frame_tick
);

   localparam logic [POS_W-1:0]        c_init        = BIRD_Y_INIT[POS_W-1:0];
   localparam logic signed [Y_W-1:0]   c_floor       = FLOOR_Y[Y_W-1:0];
   localparam logic signed [Y_W-1:0]   c_ceil        = CEIL_Y[Y_W-1:0];
   localparam logic signed [VEL_W-1:0] c_gravity     = GRAVITY[VEL_W-1:0];
   localparam logic signed [VEL_W-1:0] c_flap_vel    = FLAP_VEL[VEL_W-1:0];
   localparam logic signed [VEL_W-1:0] c_vel_max     = VEL_MAX[VEL_W-1:0];
   localparam logic [15:0]             c_dead_frames = DEAD_FRAMES[15:0];

   // Reset synchroniser: asserts asynchronously, releases on a clock edge
   logic r_rst_meta;
   logic r_rst_sync;
   logic w_rst_n;

   // V_SYNC synchroniser and edge detector
   logic r_vs_meta;
   logic r_vs_sync;
   logic r_vs_prev;
   logic w_vs_fall;
   logic r_frame_tick;

   // Game and physics state
   game_state_t             r_state;
   game_state_t             w_state_n;
   logic signed [VEL_W-1:0] r_vel;
   logic signed [VEL_W-1:0] w_vel_n;
   logic [POS_W-1:0]        r_bird_y;
   logic [POS_W-1:0]        w_bird_y_n;
   logic [15:0]             r_score;
   logic [15:0]             w_score_n;
   logic [15:0]             r_dead_cnt;
   logic [15:0]             w_dead_cnt_n;

   // Physics datapath
   logic                    w_flap_req;
   logic signed [VEL_W-1:0] w_vel_grav;
   logic signed [VEL_W-1:0] w_vel_step;
   logic signed [Y_W-1:0]   w_y_sum;
   logic signed [Y_W-1:0]   w_y_clamp;
   logic                    w_hit_floor;

   // Two-flop reset release synchroniser
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst_n = r_rst_sync;

   // V_SYNC is idle-high, so the sync chain resets high to avoid a false tick
   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_vs_meta    <= 1'b1;
         r_vs_sync    <= 1'b1;
         r_vs_prev    <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_vs_meta    <= i_vga_vs;
         r_vs_sync    <= r_vs_meta;
         r_vs_prev    <= r_vs_sync;
         r_frame_tick <= w_vs_fall;
      end
   end

   assign w_vs_fall = r_vs_prev & ~r_vs_sync;

   ps2_space_decoder u_decoder (
      .clk         (CLOCK_50),
      .rst_n       (w_rst_n),
      .i_key_valid (i_key_valid),
      .i_key_data  (i_key_data),
      .i_consume   (r_frame_tick),
      .o_flap_req  (w_flap_req)
   );

   // Candidate velocity and row for this frame; only committed on a tick
   always_comb begin
      w_vel_grav = r_vel + c_gravity;
      if (w_flap_req) begin
         w_vel_step = c_flap_vel;
      end else if (w_vel_grav > c_vel_max) begin
         w_vel_step = c_vel_max;
      end else begin
         w_vel_step = w_vel_grav;
      end
      w_y_sum = $signed({{(Y_W-POS_W){1'b0}}, r_bird_y})
              + $signed({{(Y_W-VEL_W){w_vel_step[VEL_W-1]}}, w_vel_step});
      w_y_clamp   = (w_y_sum < c_ceil) ? c_ceil : w_y_sum;
      w_hit_floor = (w_y_clamp >= c_floor);
   end

   // Game state and physics registers
   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= GS_IDLE;
         r_vel      <= '0;
         r_bird_y   <= c_init;
         r_score    <= '0;
         r_dead_cnt <= '0;
      end else begin
         r_state    <= w_state_n;
         r_vel      <= w_vel_n;
         r_bird_y   <= w_bird_y_n;
         r_score    <= w_score_n;
         r_dead_cnt <= w_dead_cnt_n;
      end
   end

   // Game FSM next-state; everything holds between frame ticks
   always_comb begin
      w_state_n    = r_state;
      w_vel_n      = r_vel;
      w_bird_y_n   = r_bird_y;
      w_score_n    = r_score;
      w_dead_cnt_n = r_dead_cnt;
      if (r_frame_tick) begin
         case (r_state)
            GS_IDLE: begin
               w_bird_y_n = c_init;
               w_vel_n    = '0;
               if (w_flap_req) begin
                  // The starting flap moves the bird on this very tick
                  w_state_n  = GS_PLAY;
                  w_score_n  = '0;
                  w_vel_n    = c_flap_vel;
                  w_bird_y_n = w_y_clamp[POS_W-1:0];
               end
            end
            GS_PLAY: begin
               w_vel_n = w_vel_step;
               if (i_collide || w_hit_floor) begin
                  // Death takes priority over a simultaneous pipe pass
                  w_state_n    = GS_DEAD;
                  w_dead_cnt_n = '0;
                  w_bird_y_n   = w_hit_floor ? c_floor[POS_W-1:0]
                                             : w_y_clamp[POS_W-1:0];
               end else begin
                  w_bird_y_n = w_y_clamp[POS_W-1:0];
                  if (i_pipe_pass) begin
                     w_score_n = sat_inc16(r_score);
                  end
               end
            end
            GS_DEAD: begin
               if (r_dead_cnt < c_dead_frames) begin
                  // Lock-out window: pending flaps are consumed and dropped
                  w_dead_cnt_n = r_dead_cnt + 16'd1;
               end else if (w_flap_req) begin
                  w_state_n    = GS_IDLE;
                  w_bird_y_n   = c_init;
                  w_vel_n      = '0;
                  w_dead_cnt_n = '0;
               end
            end
            default: begin
               w_state_n    = GS_IDLE;
               w_bird_y_n   = c_init;
               w_vel_n      = '0;
               w_dead_cnt_n = '0;
            end
         endcase
      end
   end

   assign o_bird_y     = {{(32-POS_W){1'b0}}, r_bird_y};
   assign o_game_state = r_state;
   assign o_score      = r_score;
   assign o_frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_flappy_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flappy_game_sequencer
//  Description : Self-checking bench for flappy_game_sequencer: frame-tick
//                timing, a per-frame vector table for flaps/scoring/death,
//                the dead lock-out window, floor death and mid-code reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flappy_game_sequencer;

   logic        clk;
   logic        resetn;
   logic        vga_vs;
   logic        key_valid;
   logic [7:0]  key_data;
   logic        collide;
   logic        pipe_pass;
   logic [31:0] bird_y;
   logic [1:0]  game_state;
   logic [15:0] score;
   logic        frame_tick;

   int n_tests;
   int n_fail;

   typedef struct {
      int         nk;
      logic [7:0] k0;
      logic [7:0] k1;
      logic [7:0] k2;
      logic       c;
      logic       p;
      int         st;
      int         y;
      int         sc;
   } vec_t;

   vec_t vecs[15];

   flappy_game_sequencer dut (
      .CLOCK_50     (clk),
      .resetn       (resetn),
      .i_vga_vs     (vga_vs),
      .i_key_valid  (key_valid),
      .i_key_data   (key_data),
      .i_collide    (collide),
      .i_pipe_pass  (pipe_pass),
      .o_bird_y     (bird_y),
      .o_game_state (game_state),
      .o_score      (score),
      .o_frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(int nk, logic [7:0] k0, logic [7:0] k1, logic [7:0] k2,
                               logic c, logic p, int st, int y, int sc);
      vec_t v;
      v.nk = nk; v.k0 = k0; v.k1 = k1; v.k2 = k2;
      v.c = c; v.p = p; v.st = st; v.y = y; v.sc = sc;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input int st, input int y, input int sc);
      check({name, ".state"}, int'(game_state), st);
      check({name, ".bird_y"}, int'(bird_y), y);
      check({name, ".score"}, int'(score), sc);
   endtask

   task automatic send_key(input logic [7:0] b);
      @(negedge clk);
      key_valid = 1'b1;
      key_data  = b;
      @(negedge clk);
      key_valid = 1'b0;
      key_data  = 8'h00;
   endtask

   // One VGA frame; returns with outputs sampled the cycle after frame_tick
   task automatic run_frame(input logic c, input logic p);
      bit found;
      collide   = c;
      pipe_pass = p;
      @(negedge clk);
      vga_vs = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk);
         #1;
         if (frame_tick) found = 1'b1;
      end
      if (!found) check("frame_tick_timeout", 0, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      vga_vs    = 1'b1;
      collide   = 1'b0;
      pipe_pass = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // 61 dead frames: flaps at frames 30 and 60 are dropped, frame 61 restarts
   task automatic dead_seq(input int y, input int sc);
      for (int d = 1; d <= 61; d++) begin
         if (d == 30 || d == 60 || d == 61) begin
            send_key(8'hF0);
            send_key(8'h29);
            send_key(8'h29);
         end
         run_frame(1'b0, 1'b0);
         if (d < 61) begin
            check($sformatf("dead_f%0d.state", d), int'(game_state), 2);
            if (d == 1 || d == 30 || d == 60) begin
               check($sformatf("dead_f%0d.bird_y", d), int'(bird_y), y);
               check($sformatf("dead_f%0d.score", d), int'(score), sc);
            end
         end else begin
            check_out("restart", 0, 240, sc);
         end
      end
   endtask

   initial begin
      int tick_at;
      int extra;
      int m_vel;
      int m_y;
      bit m_dead;

      n_tests   = 0;
      n_fail    = 0;
      resetn    = 1'b0;
      vga_vs    = 1'b1;
      key_valid = 1'b0;
      key_data  = 8'h00;
      collide   = 1'b0;
      pipe_pass = 1'b0;

      vecs[0]  = mk(1, 8'h29, 8'h00, 8'h00, 0, 0, 1, 232, 0);
      vecs[1]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 225, 0);
      vecs[2]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 219, 0);
      vecs[3]  = mk(2, 8'hF0, 8'h29, 8'h00, 0, 0, 1, 214, 0);
      vecs[4]  = mk(1, 8'h29, 8'h00, 8'h00, 0, 0, 1, 206, 0);
      vecs[5]  = mk(3, 8'h29, 8'h29, 8'h29, 0, 0, 1, 199, 0);
      vecs[6]  = mk(2, 8'hF0, 8'h29, 8'h00, 0, 0, 1, 193, 0);
      vecs[7]  = mk(1, 8'h29, 8'h00, 8'h00, 0, 0, 1, 185, 0);
      vecs[8]  = mk(2, 8'hF0, 8'h29, 8'h00, 0, 0, 1, 178, 0);
      vecs[9]  = mk(2, 8'hE0, 8'h29, 8'h00, 0, 0, 1, 172, 0);
      vecs[10] = mk(3, 8'hE0, 8'hF0, 8'h29, 0, 0, 1, 167, 0);
      vecs[11] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 163, 1);
      vecs[12] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 160, 2);
      vecs[13] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 158, 3);
      vecs[14] = mk(0, 8'h00, 8'h00, 8'h00, 1, 1, 2, 157, 3);

      repeat (5) @(negedge clk);
      check_out("in_reset", 0, 240, 0);
      check("in_reset.frame_tick", int'(frame_tick), 0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // Three idle frames: tick lands on the 3rd edge after VS falls, once
      for (int f = 0; f < 3; f++) begin
         @(negedge clk);
         vga_vs  = 1'b0;
         tick_at = 0;
         extra   = 0;
         for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick) begin
               if (tick_at == 0) tick_at = i;
               else extra++;
            end
            if (i == 8) vga_vs = 1'b1;
         end
         check($sformatf("idle%0d.tick_latency", f), tick_at, 3);
         check($sformatf("idle%0d.extra_ticks", f), extra, 0);
         check_out($sformatf("idle%0d", f), 0, 240, 0);
      end

      // Flap, typematic, break, extended keys, scoring and collide death
      foreach (vecs[i]) begin
         if (vecs[i].nk > 0) send_key(vecs[i].k0);
         if (vecs[i].nk > 1) send_key(vecs[i].k1);
         if (vecs[i].nk > 2) send_key(vecs[i].k2);
         run_frame(vecs[i].c, vecs[i].p);
         check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].y, vecs[i].sc);
      end

      dead_seq(157, 3);

      // New game clears the score; free fall until the floor
      send_key(8'hF0);
      send_key(8'h29);
      send_key(8'h29);
      run_frame(1'b0, 1'b0);
      check_out("fall_start", 1, 232, 0);
      m_vel  = -8;
      m_y    = 232;
      m_dead = 1'b0;
      for (int f = 0; f < 60 && !m_dead; f++) begin
         m_vel = (m_vel + 1 > 10) ? 10 : m_vel + 1;
         m_y   = m_y + m_vel;
         if (m_y >= 440) begin
            m_y    = 440;
            m_dead = 1'b1;
         end
         run_frame(1'b0, 1'b0);
         check($sformatf("fall%0d.state", f), int'(game_state), m_dead ? 2 : 1);
         check($sformatf("fall%0d.bird_y", f), int'(bird_y), m_y);
      end
      check("fall_reached_floor", int'(m_dead), 1);

      dead_seq(440, 0);

      // Reset in the middle of a break sequence discards the F0 prefix
      send_key(8'hF0);
      send_key(8'h29);
      send_key(8'h29);
      run_frame(1'b0, 1'b0);
      check_out("rst_play", 1, 232, 0);
      run_frame(1'b0, 1'b1);
      check_out("rst_pass", 1, 225, 1);
      send_key(8'hF0);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_out("rst_async", 0, 240, 0);
      check("rst_async.frame_tick", int'(frame_tick), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      check_out("rst_released", 0, 240, 0);
      send_key(8'h29);
      run_frame(1'b0, 1'b0);
      check_out("rst_make", 1, 232, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
